dc_queue: RTL and testbench

//  Registered RV32I decode stage with an output queue between the instruction queue and the reg/rob/rs/slb dispatch.

---
 rtl/dc_queue_if.sv | 82 ++++++++
 rtl/dc_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_dc_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dc_queue_if.sv
// Op-code package and bus interface for the dc_queue decode stage.
// dc_queue_pkg : op codes placed in each decoded entry (0 marks an illegal entry).
// dc_queue_if  : instruction side (in_valid/in_ready/in_pc/in_instr), dispatch side
//                (out_valid/out_ready and decoded head fields) and the occupancy count.
//                slave = decode queue view, master = producer/consumer view.
package dc_queue_pkg;
    localparam logic [5:0] OP_NONE  = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;
endpackage

interface dc_queue_if #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned PcWidth     = 32,
    parameter int unsigned RegIdxWidth = 5,
    parameter int unsigned OpWidth     = 6
);
    localparam int unsigned CntWidth = $clog2(Depth) + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [PcWidth-1:0]     in_pc;
    logic [31:0]            in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [PcWidth-1:0]     out_pc;
    logic [OpWidth-1:0]     out_op;
    logic [RegIdxWidth-1:0] out_rd;
    logic [RegIdxWidth-1:0] out_rs1;
    logic [RegIdxWidth-1:0] out_rs2;
    logic [31:0]            out_imm;
    logic                   out_is_sl;
    logic                   out_illegal;
    logic [CntWidth-1:0]    count;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_is_sl, out_illegal, count
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_is_sl, out_illegal, count
    );
endinterface

// File: rtl/dc_queue.sv
// RV32I decode stage with a Depth-entry output FIFO between fetch and dispatch.
// Ports: clk, rst (sync, active-high), clr (sync flush), q (dc_queue_if.slave):
//   in_valid/in_ready/in_pc/in_instr   instruction offer from the instruction queue
//   out_valid/out_ready/out_*          decoded head entry toward dispatch
//   count                              occupied entries
module dc_queue
    import dc_queue_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned PcWidth     = 32,
    parameter int unsigned RegIdxWidth = 5,
    parameter int unsigned OpWidth     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    dc_queue_if.slave  q
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] instr;
    logic [2:0]  f3;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_sl, dec_ill;

    logic [PcWidth-1:0]     pc_q  [Depth];
    logic [OpWidth-1:0]     op_q  [Depth];
    logic [RegIdxWidth-1:0] rd_q  [Depth];
    logic [RegIdxWidth-1:0] rs1_q [Depth];
    logic [RegIdxWidth-1:0] rs2_q [Depth];
    logic [31:0]            imm_q [Depth];
    logic                   sl_q  [Depth];
    logic                   ill_q [Depth];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                push, pop;

    assign instr = q.in_instr;
    assign f3    = instr[14:12];

    // Instruction decode; illegal encodings collapse to an all-zero entry with the flag set.
    always_comb begin
        dec_op  = OP_NONE;
        dec_rd  = instr[11:7];
        dec_rs1 = instr[19:15];
        dec_rs2 = 5'd0;
        dec_imm = {{20{instr[31]}}, instr[31:20]};
        dec_sl  = 1'b0;
        dec_ill = 1'b0;
        case (instr[6:0])
            OPC_LUI: begin
                dec_op  = OP_LUI;
                dec_rs1 = 5'd0;
                dec_imm = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_op  = OP_AUIPC;
                dec_rs1 = 5'd0;
                dec_imm = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_op  = OP_JAL;
                dec_rs1 = 5'd0;
                dec_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR: dec_op = OP_JALR;
            OPC_BRANCH: begin
                dec_rd  = 5'd0;
                dec_rs2 = instr[24:20];
                dec_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                case (f3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_sl = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_sl  = 1'b1;
                dec_rd  = 5'd0;
                dec_rs2 = instr[24:20];
                dec_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                case (f3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b000: dec_op = OP_ADDI;
                    3'b010: dec_op = OP_SLTI;
                    3'b011: dec_op = OP_SLTIU;
                    3'b100: dec_op = OP_XORI;
                    3'b110: dec_op = OP_ORI;
                    3'b001: begin
                        dec_op  = OP_SLLI;
                        dec_imm = {27'b0, instr[24:20]};
                    end
                    3'b101: begin
                        dec_op  = instr[30] ? OP_SRAI : OP_SRLI;
                        dec_imm = {27'b0, instr[24:20]};
                    end
                    default: dec_op = OP_ANDI;
                endcase
            end
            OPC_OP: begin
                dec_rs2 = instr[24:20];
                dec_imm = 32'd0;
                case (f3)
                    3'b000:  dec_op = instr[30] ? OP_SUB : OP_ADD;
                    3'b001:  dec_op = OP_SLL;
                    3'b010:  dec_op = OP_SLT;
                    3'b011:  dec_op = OP_SLTU;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = instr[30] ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op  = OP_NONE;
            dec_rd  = 5'd0;
            dec_rs1 = 5'd0;
            dec_rs2 = 5'd0;
            dec_imm = 32'd0;
            dec_sl  = 1'b0;
        end
    end

    // Ready ignores out_ready: a full queue never accepts, even when the head is popping.
    assign q.in_ready  = !rst && !clr && (count_q < CntWidth'(Depth));
    assign q.out_valid = (count_q != '0);
    assign push        = q.in_valid && q.in_ready;
    assign pop         = q.out_valid && q.out_ready;

    // Pointer/count next state; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntWidth'(1);
                2'b01:   count_d = count_q - CntWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                pc_q[i]  <= '0;
                op_q[i]  <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                imm_q[i] <= '0;
                sl_q[i]  <= 1'b0;
                ill_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                pc_q[wr_ptr_q]  <= q.in_pc;
                op_q[wr_ptr_q]  <= OpWidth'(dec_op);
                rd_q[wr_ptr_q]  <= RegIdxWidth'(dec_rd);
                rs1_q[wr_ptr_q] <= RegIdxWidth'(dec_rs1);
                rs2_q[wr_ptr_q] <= RegIdxWidth'(dec_rs2);
                imm_q[wr_ptr_q] <= dec_imm;
                sl_q[wr_ptr_q]  <= dec_sl;
                ill_q[wr_ptr_q] <= dec_ill;
            end
        end
    end

    assign q.out_pc      = pc_q[rd_ptr_q];
    assign q.out_op      = op_q[rd_ptr_q];
    assign q.out_rd      = rd_q[rd_ptr_q];
    assign q.out_rs1     = rs1_q[rd_ptr_q];
    assign q.out_rs2     = rs2_q[rd_ptr_q];
    assign q.out_imm     = imm_q[rd_ptr_q];
    assign q.out_is_sl   = sl_q[rd_ptr_q];
    assign q.out_illegal = ill_q[rd_ptr_q];
    assign q.count       = count_q;
endmodule

// File: tb/tb_dc_queue.sv
// Directed testbench for dc_queue: reset, decode table, full/backpressure, wrap, flush, illegal.
module tb_dc_queue;
    import dc_queue_pkg::*;

    logic clk, rst, clr;
    int   tests = 0;
    int   fails = 0;

    dc_queue_if #(.Depth(4), .PcWidth(32), .RegIdxWidth(5), .OpWidth(6)) bus ();

    dc_queue #(.Depth(4), .PcWidth(32), .RegIdxWidth(5), .OpWidth(6)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        sl, ill;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h80; bus.in_instr = 32'hfff00093; bus.out_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
            tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset count: got %0d want 0", bus.count); end
            tests++; if ({bus.out_pc, bus.out_op, bus.out_imm} !== 70'd0) begin fails++; $display("FAIL reset head: pc %h op %0d imm %h want zeros", bus.out_pc, bus.out_op, bus.out_imm); end
        end
        rst = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset release in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80) begin
            fails++; $display("FAIL reset first accept: count %0d valid %b pc %h want 1 1 80", bus.count, bus.out_valid, bus.out_pc);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset drain count: got %0d want 0", bus.count); end
    endtask

    task automatic test_decode();
        vec_t v [11];
        logic [54:0] got, exp;
        v[0]  = '{32'hfff00093, OP_ADDI,  5'd1, 5'd0, 5'd0, 32'hffffffff, 1'b0, 1'b0};
        v[1]  = '{32'hfe000ee3, OP_BEQ,   5'd0, 5'd0, 5'd0, 32'hfffffffc, 1'b0, 1'b0};
        v[2]  = '{32'h12345037, OP_LUI,   5'd0, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0};
        v[3]  = '{32'h00812283, OP_LW,    5'd5, 5'd2, 5'd0, 32'h00000008, 1'b1, 1'b0};
        v[4]  = '{32'hfe312e23, OP_SW,    5'd0, 5'd2, 5'd3, 32'hfffffffc, 1'b1, 1'b0};
        v[5]  = '{32'h4030d093, OP_SRAI,  5'd1, 5'd1, 5'd0, 32'h00000003, 1'b0, 1'b0};
        v[6]  = '{32'h402081b3, OP_SUB,   5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b0};
        v[7]  = '{32'h008000ef, OP_JAL,   5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0, 1'b0};
        v[8]  = '{32'hfffff117, OP_AUIPC, 5'd2, 5'd0, 5'd0, 32'hfffff000, 1'b0, 1'b0};
        v[9]  = '{32'h004280e7, OP_JALR,  5'd1, 5'd5, 5'd0, 32'h00000004, 1'b0, 1'b0};
        v[10] = '{32'h00003083, OP_NONE,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
        for (int k = 0; k < 11; k++) begin
            bus.in_valid = 1'b1; bus.in_pc = 32'h100 + 32'(4 * k); bus.in_instr = v[k].instr;
            tick();
            bus.in_valid = 1'b0;
            got = {bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_is_sl, bus.out_illegal};
            exp = {v[k].op, v[k].rd, v[k].rs1, v[k].rs2, v[k].imm, v[k].sl, v[k].ill};
            tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * k)) begin
                fails++; $display("FAIL decode[%0d] head: valid %b pc %h", k, bus.out_valid, bus.out_pc);
            end
            tests++; if (got !== exp) begin
                fails++; $display("FAIL decode[%0d] fields {op,rd,rs1,rs2,imm,sl,ill}: got %h want %h", k, got, exp);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0; bus.in_instr = 32'hfff00093;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_pc = 32'h200 + 32'(4 * i);
            tick();
        end
        bus.in_pc = 32'h210;
        tests++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL full: count %0d in_ready %b want 4 0", bus.count, bus.in_ready); end
        tick();
        tests++; if (bus.count !== 3'd4 || bus.out_pc !== 32'h200) begin fails++; $display("FAIL full hold: count %0d pc %h want 4 200", bus.count, bus.out_pc); end
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full no push-through: in_ready %b want 0", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.count !== 3'd3 || bus.out_pc !== 32'h204 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL full pop1: count %0d pc %h rdy %b want 3 204 1", bus.count, bus.out_pc, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.count !== 3'd3 || bus.out_pc !== 32'h208) begin fails++; $display("FAIL full push+pop: count %0d pc %h want 3 208", bus.count, bus.out_pc); end
        tick();
        tests++; if (bus.count !== 3'd2 || bus.out_pc !== 32'h20c) begin fails++; $display("FAIL full order3: count %0d pc %h want 2 20c", bus.count, bus.out_pc); end
        tick();
        tests++; if (bus.count !== 3'd1 || bus.out_pc !== 32'h210) begin fails++; $display("FAIL full order4: count %0d pc %h want 1 210", bus.count, bus.out_pc); end
        tick();
        bus.out_ready = 1'b0;
        tests++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL full drain: count %0d valid %b want 0 0", bus.count, bus.out_valid); end
    endtask

    task automatic test_wrap();
        int sent = 0, recv = 0, mcount = 0, cyc = 0;
        logic p, o;
        bus.in_instr = 32'hfff00093;
        while (recv < 10 && cyc < 200) begin
            bus.in_valid  = (sent < 10);
            bus.in_pc     = 32'h300 + 32'(4 * sent);
            bus.out_ready = (cyc % 2 == 0);
            #1;
            tests++; if (bus.in_ready !== (mcount < 4) || bus.count !== 3'(mcount) || bus.out_valid !== (mcount != 0)) begin
                fails++; $display("FAIL wrap cyc %0d: rdy %b count %0d valid %b want count %0d", cyc, bus.in_ready, bus.count, bus.out_valid, mcount);
            end
            p = (sent < 10) && (mcount < 4);
            o = (mcount != 0) && bus.out_ready;
            if (o) begin
                tests++; if (bus.out_pc !== 32'h300 + 32'(4 * recv)) begin
                    fails++; $display("FAIL wrap order %0d: got pc %h want %h", recv, bus.out_pc, 32'h300 + 32'(4 * recv));
                end
            end
            tick();
            sent   += int'(p);
            recv   += int'(o);
            mcount += int'(p) - int'(o);
            cyc++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tests++; if (recv != 10) begin fails++; $display("FAIL wrap timeout: received %0d want 10", recv); end
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL wrap end count: got %0d want 0", bus.count); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0; bus.in_instr = 32'hfff00093;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        tests++; if (bus.count !== 3'd3) begin fails++; $display("FAIL flush pre count: got %0d want 3", bus.count); end
        bus.in_pc = 32'h4ff; clr = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        clr = 1'b0; bus.in_valid = 1'b0;
        tests++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush: count %0d valid %b want 0 0", bus.count, bus.out_valid); end
        bus.in_valid = 1'b1; bus.in_pc = 32'h500;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.count !== 3'd1 || bus.out_pc !== 32'h500) begin fails++; $display("FAIL flush refill: count %0d pc %h want 1 500", bus.count, bus.out_pc); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h600; bus.in_instr = 32'h0000007f;
        tick();
        bus.in_pc = 32'h604; bus.in_instr = 32'hfff00093;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL illegal count: got %0d want 2", bus.count); end
        tests++; if (bus.out_pc !== 32'h600 || bus.out_illegal !== 1'b1 || bus.out_op !== OP_NONE || bus.out_rd !== 5'd0 || bus.out_imm !== 32'd0) begin
            fails++; $display("FAIL illegal head: pc %h ill %b op %0d rd %0d imm %h", bus.out_pc, bus.out_illegal, bus.out_op, bus.out_rd, bus.out_imm);
        end
        bus.out_ready = 1'b1;
        tick();
        tests++; if (bus.out_pc !== 32'h604 || bus.out_illegal !== 1'b0 || bus.out_op !== OP_ADDI || bus.out_rd !== 5'd1 || bus.out_imm !== 32'hffffffff) begin
            fails++; $display("FAIL illegal follower: pc %h ill %b op %0d rd %0d imm %h", bus.out_pc, bus.out_illegal, bus.out_op, bus.out_rd, bus.out_imm);
        end
        tick();
        bus.out_ready = 1'b0;
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL illegal drain count: got %0d want 0", bus.count); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_full();
        test_wrap();
        test_flush();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
